// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - opcode constants, format enumeration and shamt width helper
//
// Shared by imm_decode and imm_gen_pipe. No ports.

package imm_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    // RV64 shifts by up to 63, RV32 by up to 31.
    function automatic int shamt_w(input int xlen);
        return (xlen == 64) ? 6 : 5;
    endfunction

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational immediate, format and PC-relative target decode
//
// Ports:
//   instr_i   in  32    raw instruction word
//   pc_i      in  XLEN  PC of instr_i
//   imm_o     out XLEN  sign/zero-extended immediate
//   target_o  out XLEN  pc + imm for B, J, AUIPC; pc otherwise
//   fmt_o     out 3     instruction format code
//   illegal_o out 1     opcode not recognised

module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] imm_o,
    output logic [XLEN-1:0] target_o,
    output logic [2:0]      fmt_o,
    output logic            illegal_o
);

    localparam int SW = shamt_w(XLEN);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    fmt_e        fmt_d;
    logic [31:0] imm32;
    logic        is_shift;
    logic        pc_rel;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];

    always_comb begin
        fmt_d    = FMT_ILL;
        imm32    = '0;
        is_shift = 1'b0;
        pc_rel   = 1'b0;
        case (opcode)
            OP_LOAD, OP_JALR: begin
                fmt_d = FMT_I;
                imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OP_IMM: begin
                fmt_d    = FMT_I;
                imm32    = {{20{instr_i[31]}}, instr_i[31:20]};
                is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
            end
            OP_STORE: begin
                fmt_d = FMT_S;
                imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            OP_BRANCH: begin
                fmt_d  = FMT_B;
                pc_rel = 1'b1;
                imm32  = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                          instr_i[30:25], instr_i[11:8], 1'b0};
            end
            OP_LUI: begin
                fmt_d = FMT_U;
                imm32 = {instr_i[31:12], 12'b0};
            end
            OP_AUIPC: begin
                fmt_d  = FMT_U;
                pc_rel = 1'b1;
                imm32  = {instr_i[31:12], 12'b0};
            end
            OP_JAL: begin
                fmt_d  = FMT_J;
                pc_rel = 1'b1;
                imm32  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                          instr_i[20], instr_i[30:21], 1'b0};
            end
            OP_REG: begin
                fmt_d = FMT_R;
            end
            default: begin
                fmt_d = FMT_ILL;
            end
        endcase
    end

    // Shift amounts are zero-extended so funct7 (e.g. the srai bit) never leaks in.
    assign imm_o     = is_shift ? XLEN'(instr_i[20 +: SW]) : XLEN'($signed(imm32));
    assign target_o  = pc_rel ? (pc_i + imm_o) : pc_i;
    assign fmt_o     = fmt_d;
    assign illegal_o = (fmt_d == FMT_ILL);

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined immediate generator with optional skid buffer
//
// Ports:
//   clk, rst_n                     clock (rising), async active-low reset
//   in_valid/in_ready              input handshake
//   in_instr, in_pc, in_tag        instruction, its PC, opaque sideband
//   out_valid/out_ready            output handshake
//   out_imm, out_target, out_fmt,  decoded result, registered
//   out_illegal, out_tag

module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int SKID  = 1,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [XLEN-1:0]  out_target,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam int W = 2 * XLEN + 3 + 1 + TAG_W;

    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] dec_target;
    logic [2:0]      dec_fmt;
    logic            dec_ill;
    logic [W-1:0]    in_data;

    logic            main_v_q, main_v_d;
    logic [W-1:0]    main_q, main_d;
    logic            in_fire, out_fire;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr_i   (in_instr),
        .pc_i      (in_pc),
        .imm_o     (dec_imm),
        .target_o  (dec_target),
        .fmt_o     (dec_fmt),
        .illegal_o (dec_ill)
    );

    assign in_data  = {dec_imm, dec_target, dec_fmt, dec_ill, in_tag};
    assign in_fire  = in_valid && in_ready;
    assign out_fire = main_v_q && out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic         skid_v_q, skid_v_d;
            logic [W-1:0] skid_q, skid_d;

            // Registered ready: the skid slot absorbs the one input that
            // arrives in the cycle the stall is first seen.
            assign in_ready = !skid_v_q;

            always_comb begin
                main_v_d = main_v_q;
                main_d   = main_q;
                skid_v_d = skid_v_q;
                skid_d   = skid_q;
                if (!main_v_q || out_fire) begin
                    if (skid_v_q) begin
                        // in_ready is low here, so no input competes with the skid entry.
                        main_v_d = 1'b1;
                        main_d   = skid_q;
                        skid_v_d = 1'b0;
                    end else begin
                        main_v_d = in_fire;
                        if (in_fire) begin
                            main_d = in_data;
                        end
                    end
                end else if (in_fire) begin
                    skid_v_d = 1'b1;
                    skid_d   = in_data;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    skid_v_q <= 1'b0;
                    skid_q   <= '0;
                end else begin
                    skid_v_q <= skid_v_d;
                    skid_q   <= skid_d;
                end
            end
        end else begin : g_noskid
            assign in_ready = !main_v_q || out_ready;

            always_comb begin
                main_v_d = main_v_q;
                main_d   = main_q;
                if (in_fire) begin
                    main_v_d = 1'b1;
                    main_d   = in_data;
                end else if (out_fire) begin
                    main_v_d = 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v_q <= 1'b0;
            main_q   <= '0;
        end else begin
            main_v_q <= main_v_d;
            main_q   <= main_d;
        end
    end

    assign out_valid = main_v_q;
    assign {out_imm, out_target, out_fmt, out_illegal, out_tag} = main_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - bench for imm_gen_pipe (RV32 skid, RV64 skid, RV32 no-skid)

module tb_imm_gen_pipe;

    typedef struct packed {
        logic [63:0] imm;
        logic [63:0] target;
        logic [2:0]  fmt;
        logic        ill;
        logic [4:0]  tag;
    } res_t;

    localparam int ND   = 3;
    localparam int MAXN = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        iv   [ND];
    logic [31:0] ii   [ND];
    logic [63:0] ip   [ND];
    logic [4:0]  it   [ND];
    logic        ordy [ND];

    logic        ir0, ov0, oil0, ir1, ov1, oil1, ir2, ov2, oil2;
    logic [31:0] oi0, ot0, oi2, ot2;
    logic [63:0] oi1, ot1;
    logic [2:0]  of0, of1, of2;
    logic [4:0]  otg0, otg1, otg2;

    logic o_v [ND];
    logic i_r [ND];
    res_t o_res [ND];

    imm_gen_pipe #(.XLEN(32), .SKID(1), .TAG_W(5)) u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir0), .in_instr(ii[0]),
        .in_pc(ip[0][31:0]), .in_tag(it[0]), .out_valid(ov0), .out_ready(ordy[0]),
        .out_imm(oi0), .out_target(ot0), .out_fmt(of0), .out_illegal(oil0), .out_tag(otg0));

    imm_gen_pipe #(.XLEN(64), .SKID(1), .TAG_W(5)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir1), .in_instr(ii[1]),
        .in_pc(ip[1]), .in_tag(it[1]), .out_valid(ov1), .out_ready(ordy[1]),
        .out_imm(oi1), .out_target(ot1), .out_fmt(of1), .out_illegal(oil1), .out_tag(otg1));

    imm_gen_pipe #(.XLEN(32), .SKID(0), .TAG_W(5)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir2), .in_instr(ii[2]),
        .in_pc(ip[2][31:0]), .in_tag(it[2]), .out_valid(ov2), .out_ready(ordy[2]),
        .out_imm(oi2), .out_target(ot2), .out_fmt(of2), .out_illegal(oil2), .out_tag(otg2));

    always_comb begin
        o_v[0] = ov0; i_r[0] = ir0; o_res[0] = {32'h0, oi0, 32'h0, ot0, of0, oil0, otg0};
        o_v[1] = ov1; i_r[1] = ir1; o_res[1] = {oi1, ot1, of1, oil1, otg1};
        o_v[2] = ov2; i_r[2] = ir2; o_res[2] = {32'h0, oi2, 32'h0, ot2, of2, oil2, otg2};
    end

    logic [31:0] s_instr [ND][MAXN];
    logic [63:0] s_pc    [ND][MAXN];
    logic [4:0]  s_tag   [ND][MAXN];
    int          s_n     [ND];
    res_t        g_res   [ND][MAXN];
    int          g_n     [ND];
    int          pos     [ND];
    int          stall_err [ND];
    int          done_cyc  [ND];
    logic        rdy_hist  [ND][32];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic int xlen_of(input int d);
        return (d == 1) ? 64 : 32;
    endfunction

    // Reference decode from the ISA field definitions, using integer arithmetic.
    function automatic res_t model(input logic [31:0] instr, input logic [63:0] pc,
                                   input int xlen, input logic [4:0] tag);
        res_t        r;
        longint      v;
        logic [2:0]  fmt;
        bit          rel;
        logic [63:0] mask, p;
        logic [2:0]  f3;
        f3   = instr[14:12];
        mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        v    = 0;
        fmt  = 3'd7;
        rel  = 0;
        case (instr[6:0])
            7'h03, 7'h67: begin fmt = 3'd1; v = $signed(instr[31:20]); end
            7'h13: begin
                fmt = 3'd1;
                if (f3 == 3'd1 || f3 == 3'd5)
                    v = (xlen == 64) ? longint'(instr[25:20]) : longint'(instr[24:20]);
                else
                    v = $signed(instr[31:20]);
            end
            7'h23: begin fmt = 3'd2; v = $signed({instr[31:25], instr[11:7]}); end
            7'h63: begin
                fmt = 3'd3; rel = 1;
                v = instr[31] ? -4096 : 0;
                v = v + longint'(instr[7]) * 2048 + longint'(instr[30:25]) * 32
                      + longint'(instr[11:8]) * 2;
            end
            7'h37, 7'h17: begin
                fmt = 3'd4; rel = (instr[6:0] == 7'h17);
                v = longint'($signed(instr[31:12])) * 4096;
            end
            7'h6F: begin
                fmt = 3'd5; rel = 1;
                v = instr[31] ? -1048576 : 0;
                v = v + longint'(instr[19:12]) * 4096 + longint'(instr[20]) * 2048
                      + longint'(instr[30:21]) * 2;
            end
            7'h33: begin fmt = 3'd0; v = 0; end
            default: begin fmt = 3'd7; v = 0; end
        endcase
        p        = pc & mask;
        r.imm    = v & mask;
        r.target = rel ? ((p + v) & mask) : p;
        r.fmt    = fmt;
        r.ill    = (fmt == 3'd7);
        r.tag    = tag;
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [10];
        logic [31:0] w;
        ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};
        w = $urandom;
        w[6:0] = ops[$urandom_range(0, 9)];
        return w;
    endfunction

    // mode 0: out_ready=1, 1: random in_valid/out_ready, 2: out_ready low in cycles 2..4, 3: out_ready=0
    task automatic run(input int mode, input int budget);
        bit   pending [ND];
        bit   prev_stall [ND];
        res_t held [ND];
        int   cycles;
        bit   done;
        for (int d = 0; d < ND; d++) begin
            pos[d] = 0; g_n[d] = 0; stall_err[d] = 0; done_cyc[d] = -1;
            pending[d] = 0; prev_stall[d] = 0;
            for (int c = 0; c < 32; c++) rdy_hist[d][c] = 1'bx;
        end
        cycles = 0;
        done = 0;
        while (cycles < budget && !done) begin
            for (int d = 0; d < ND; d++) begin
                if (!pending[d] && pos[d] < s_n[d])
                    pending[d] = (mode != 1) || ($urandom_range(0, 3) != 0);
                iv[d] = pending[d];
                if (pending[d]) begin
                    ii[d] = s_instr[d][pos[d]]; ip[d] = s_pc[d][pos[d]]; it[d] = s_tag[d][pos[d]];
                end else begin
                    ii[d] = $urandom; ip[d] = {$urandom, $urandom}; it[d] = 5'($urandom);
                end
                case (mode)
                    0:       ordy[d] = 1'b1;
                    1:       ordy[d] = ($urandom_range(0, 2) != 0);
                    2:       ordy[d] = !(cycles >= 2 && cycles <= 4);
                    default: ordy[d] = 1'b0;
                endcase
            end
            @(negedge clk);
            done = 1;
            for (int d = 0; d < ND; d++) begin
                if (cycles < 32) rdy_hist[d][cycles] = i_r[d];
                if (prev_stall[d] && (!o_v[d] || o_res[d] !== held[d])) stall_err[d]++;
                prev_stall[d] = o_v[d] && !ordy[d];
                held[d] = o_res[d];
                if (o_v[d] && ordy[d]) begin
                    if (g_n[d] < MAXN) g_res[d][g_n[d]] = o_res[d];
                    g_n[d]++;
                    if (g_n[d] == s_n[d]) done_cyc[d] = cycles + 1;
                end
                if (iv[d] && i_r[d]) begin
                    pos[d]++;
                    pending[d] = 0;
                end
                if (g_n[d] < s_n[d]) done = 0;
            end
            cycles++;
            @(posedge clk);
            #1;
        end
        for (int d = 0; d < ND; d++) begin
            iv[d] = 1'b0;
            ordy[d] = 1'b1;
        end
    endtask

    task automatic check_stream(input string name);
        res_t e;
        for (int d = 0; d < ND; d++) begin
            n_cmp++;
            if (g_n[d] !== s_n[d]) begin
                n_bad++;
                $display("FAIL %s count d%0d: got %0d results, expected %0d", name, d, g_n[d], s_n[d]);
            end
            for (int i = 0; i < s_n[d] && i < g_n[d]; i++) begin
                e = model(s_instr[d][i], s_pc[d][i], xlen_of(d), s_tag[d][i]);
                n_cmp++;
                if (g_res[d][i] !== e) begin
                    n_bad++;
                    $display("FAIL %s d%0d[%0d]: got %h expected %h", name, d, i, g_res[d][i], e);
                end
            end
            n_cmp++;
            if (stall_err[d] !== 0) begin
                n_bad++;
                $display("FAIL %s stable d%0d: %0d output changes while stalled, expected 0",
                         name, d, stall_err[d]);
            end
        end
    endtask

    task automatic test_reset();
        res_t e;
        rst_n = 1'b0;
        for (int d = 0; d < ND; d++) begin
            iv[d] = 1'b1; ii[d] = 32'h001000EF; ip[d] = 64'h1000; it[d] = 5'd9; ordy[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            n_cmp++;
            if (o_v[d] !== 1'b0 || o_res[d] !== '0 || i_r[d] !== 1'b1) begin
                n_bad++;
                $display("FAIL reset d%0d: valid=%b res=%h ready=%b, expected valid=0 res=0 ready=1",
                         d, o_v[d], o_res[d], i_r[d]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            iv[d] = 1'b0;
            e = model(32'h001000EF, 64'h1000, xlen_of(d), 5'd9);
            n_cmp++;
            if (o_v[d] !== 1'b1 || o_res[d] !== e) begin
                n_bad++;
                $display("FAIL first_op d%0d: valid=%b res=%h, expected valid=1 res=%h",
                         d, o_v[d], o_res[d], e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [31:0] v32 [8];
        logic [63:0] p32 [8];
        logic [31:0] v64 [4];
        logic [63:0] p64 [4];
        v32 = '{32'hFE000EE3, 32'h001000EF, 32'h01F09093, 32'h4030D093,
                32'h0000007F, 32'h02509093, 32'h80000097, 32'h00208033};
        p32 = '{64'h100, 64'h1000, 64'h0, 64'h0, 64'h2000, 64'h0, 64'h10, 64'h40};
        v64 = '{32'h800000B7, 32'hFE000EE3, 32'h02509093, 32'h00001097};
        p64 = '{64'h1234, 64'h100, 64'h0, 64'hFFFF_FFFF_FFFF_F800};
        for (int i = 0; i < 8; i++) begin
            s_instr[0][i] = v32[i]; s_pc[0][i] = p32[i]; s_tag[0][i] = 5'(i);
            s_instr[2][i] = v32[i]; s_pc[2][i] = p32[i]; s_tag[2][i] = 5'(i + 10);
        end
        for (int i = 0; i < 4; i++) begin
            s_instr[1][i] = v64[i]; s_pc[1][i] = p64[i]; s_tag[1][i] = 5'(i + 20);
        end
        s_n[0] = 8; s_n[1] = 4; s_n[2] = 8;
        run(0, 50);
        check_stream("directed");
        if (g_n[0] == 8 && g_n[1] == 4) begin
            n_cmp++;
            if (g_res[0][0].imm !== 64'hFFFF_FFFC || g_res[0][0].target !== 64'hFC || g_res[0][0].fmt !== 3'd3) begin
                n_bad++; $display("FAIL beq_lit: got %h expected imm FFFFFFFC target FC fmt 3", g_res[0][0]);
            end
            n_cmp++;
            if (g_res[0][1].imm !== 64'h800 || g_res[0][1].target !== 64'h1800 || g_res[0][1].fmt !== 3'd5) begin
                n_bad++; $display("FAIL jal_lit: got %h expected imm 800 target 1800 fmt 5", g_res[0][1]);
            end
            n_cmp++;
            if (g_res[0][2].imm !== 64'h1F || g_res[0][3].imm !== 64'h3 || g_res[0][5].imm !== 64'h5) begin
                n_bad++; $display("FAIL shamt32_lit: got %h %h %h expected 1f 3 5",
                                  g_res[0][2].imm, g_res[0][3].imm, g_res[0][5].imm);
            end
            n_cmp++;
            if (g_res[0][4].ill !== 1'b1 || g_res[0][4].fmt !== 3'd7 || g_res[0][4].imm !== 64'h0
                || g_res[0][4].target !== 64'h2000) begin
                n_bad++; $display("FAIL illegal_lit: got %h expected ill 1 fmt 7 imm 0 target 2000", g_res[0][4]);
            end
            n_cmp++;
            if (g_res[0][6].target !== 64'h8000_0010) begin
                n_bad++; $display("FAIL auipc32_lit: got %h expected 80000010", g_res[0][6].target);
            end
            n_cmp++;
            if (g_res[1][0].imm !== 64'hFFFF_FFFF_8000_0000 || g_res[1][0].target !== 64'h1234
                || g_res[1][0].fmt !== 3'd4) begin
                n_bad++; $display("FAIL lui64_lit: got %h expected imm FFFFFFFF80000000 target 1234 fmt 4", g_res[1][0]);
            end
            n_cmp++;
            if (g_res[1][2].imm !== 64'd37 || g_res[1][3].target !== 64'h800) begin
                n_bad++; $display("FAIL rv64_lit: got shamt %h target %h expected 25 and 800",
                                  g_res[1][2].imm, g_res[1][3].target);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [6:0] got_bits;
        logic [6:0] exp_bits;
        for (int d = 0; d < ND; d++) begin
            for (int i = 0; i < 6; i++) begin
                s_instr[d][i] = rand_instr(); s_pc[d][i] = {$urandom, $urandom}; s_tag[d][i] = 5'(i + 1);
            end
            s_n[d] = 6;
        end
        run(2, 60);
        check_stream("backpressure");
        for (int d = 0; d < ND; d++) begin
            for (int c = 0; c < 7; c++) got_bits[c] = rdy_hist[d][c];
            exp_bits = (d == 2) ? 7'b1100011 : 7'b1000111;
            n_cmp++;
            if (got_bits !== exp_bits) begin
                n_bad++;
                $display("FAIL in_ready_trace d%0d: got %b expected %b (bit n = cycle n)", d, got_bits, exp_bits);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int d = 0; d < ND; d++) begin
            for (int i = 0; i < 12; i++) begin
                s_instr[d][i] = rand_instr(); s_pc[d][i] = {$urandom, $urandom}; s_tag[d][i] = 5'($urandom);
            end
            s_n[d] = 12;
        end
        run(0, 60);
        check_stream("back_to_back");
        for (int d = 0; d < ND; d++) begin
            n_cmp++;
            if (done_cyc[d] !== 13) begin
                n_bad++;
                $display("FAIL throughput d%0d: 12 ops took %0d cycles, expected 13", d, done_cyc[d]);
            end
        end
    endtask

    task automatic test_random();
        for (int d = 0; d < ND; d++) begin
            for (int i = 0; i < 40; i++) begin
                s_instr[d][i] = rand_instr(); s_pc[d][i] = {$urandom, $urandom}; s_tag[d][i] = 5'($urandom);
            end
            s_n[d] = 40;
        end
        run(1, 2000);
        check_stream("random");
    endtask

    task automatic test_reset_midstream();
        for (int d = 0; d < ND; d++) begin
            for (int i = 0; i < 3; i++) begin
                s_instr[d][i] = rand_instr(); s_pc[d][i] = {$urandom, $urandom}; s_tag[d][i] = 5'(i + 1);
            end
            s_n[d] = 3;
        end
        run(3, 4);
        n_cmp++;
        if (pos[0] !== 2 || o_v[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL preload: got accepted=%0d valid=%b expected accepted=2 valid=1", pos[0], o_v[0]);
        end
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            n_cmp++;
            if (o_v[d] !== 1'b0 || i_r[d] !== 1'b1) begin
                n_bad++;
                $display("FAIL midreset d%0d: valid=%b ready=%b expected valid=0 ready=1", d, o_v[d], i_r[d]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            for (int i = 0; i < 3; i++) begin
                s_instr[d][i] = rand_instr(); s_pc[d][i] = {$urandom, $urandom}; s_tag[d][i] = 5'(i + 20);
            end
            s_n[d] = 3;
        end
        run(0, 30);
        check_stream("after_reset");
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < ND; d++) begin
            iv[d] = 1'b0; ii[d] = '0; ip[d] = '0; it[d] = '0; ordy[d] = 1'b1; s_n[d] = 0;
        end
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Pipelined, parametrised immediate generator for the decode stage. It accepts one instruction per cycle on a valid/ready input and decodes every RV32I/RV64I immediate format, including U, JALR and shift-amount forms. It also computes the PC-relative target for branch, jump and AUIPC. Results pass through a registered output stage with an optional skid buffer, so fetch and execute stay decoupled at full throughput.

Parameters:
XLEN, 32, datapath width; legal values are 32 and 64.
SKID, 1, 1 = two-entry skid buffer (registered in_ready, 1 op/cycle); 0 = single register (in_ready combinational from out_ready).
TAG_W, 5, width of the opaque sideband tag carried alongside each instruction.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  input instruction valid
in_ready  out  1  block can accept this cycle
in_instr  in  32  raw instruction word
in_pc  in  XLEN  PC of in_instr
in_tag  in  TAG_W  sideband, passed through unchanged
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_imm  out  XLEN  sign/zero-extended immediate
out_target  out  XLEN  pc + imm, modulo 2^XLEN
out_fmt  out  3  format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 illegal
out_illegal  out  1  opcode not recognised
out_tag  out  TAG_W  tag of the result

Behaviour:
- Reset is asynchronous, active-low, and applies immediately.
  - out_valid=0; out_imm, out_target, out_fmt, out_illegal and out_tag are all 0.
  - Skid entry is cleared; in_ready=1 after reset.
  - Asserting reset mid-stream discards all in-flight entries; nothing is replayed.
- Opcode decode (instr[6:0]):
  - I format: 0000011 (load), 0010011 (op-imm), 1100111 (jalr).
  - S format: 0100011.
  - B format: 1100011.
  - U format: 0110111 (lui), 0010111 (auipc).
  - J format: 1101111.
  - R format: 0110011; imm=0.
  - Any other opcode: fmt=7, illegal=1, imm=0, target=pc. It still handshakes normally.
- Immediates are sign-extended from instr[31] to XLEN. U-format is {instr[31:12],12'b0}, then sign-extended to XLEN.
- Shift immediates: op-imm with funct3=001 or 101 gives imm = zero-extended shamt.
  - XLEN=32: instr[24:20].
  - XLEN=64: instr[25:20].
  - funct7 bits never appear in imm.
- out_target = pc+imm for B, J and AUIPC; it equals pc for all other formats. Overflow wraps silently.
- Latency is 1 cycle: an input accepted at edge N is visible on out_* after edge N.
- Transfer rules:
  - Input transfer: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
  - While out_valid && !out_ready, all out_* hold stable.
- SKID=1:
  - Main register plus one skid register.
  - in_ready = !skid_full, registered.
  - When main is stalled and an input arrives, it goes to skid and in_ready drops the next cycle.
  - When out_ready is seen, skid moves to main and in_ready rises.
  - Simultaneous output transfer and input transfer with skid empty: main reloads with the new result, no bubble.
- SKID=0: in_ready = !out_valid || out_ready.
- Ordering is strict FIFO. No drop and no duplication under any out_ready pattern.
- in_valid while in_ready=0: the input is ignored and the producer must hold it.

Decomposition:
- Package imm_pkg contains:
  - opcode localparams;
  - fmt_e enumeration (R, I, S, B, U, J, ILL = 0..5, 7);
  - shamt-width constant derived from XLEN.
- Sub-module imm_decode: purely combinational (instr, pc -> imm, target, fmt, illegal), parametrised by XLEN.
- imm_gen_pipe holds only the handshake, register and skid logic, instantiating imm_decode on the input side.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, all outputs 0, in_ready=1. Deassert rst_n -> first accepted op appears after 1 edge.
- B and J formats, XLEN=32:
  - instr 0xFE000EE3, pc 0x100 -> imm 0xFFFFFFFC, target 0x000000FC, fmt 3.
  - instr 0x001000EF, pc 0x1000 -> imm 0x800, target 0x1800, fmt 5.
- Shift and illegal:
  - 0x01F09093 (slli 31) -> imm 0x1F.
  - 0x4030D093 (srai 3) -> imm 0x3, not 0x403.
  - 0x0000007F -> illegal=1, fmt 7, imm 0.
- XLEN=64: lui 0x800000B7 -> imm 0xFFFFFFFF80000000, target=pc, fmt 4.
- Backpressure, SKID=1:
  - Stream tags 1..6 back-to-back, out_ready low for cycles 2-4 -> in_ready low from the cycle after skid fills.
  - Outputs arrive as tags 1..6 in order, stable while stalled.
  - With out_ready=1 throughput is 1 op/cycle. Repeat with SKID=0 and expect identical ordering.
- Reset mid-stream: assert rst_n=0 with two entries buffered -> out_valid=0 immediately. After release, only newly accepted ops emerge.
